tetris_key_controller: RTL and testbench



---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/key_repeat_timer.sv | 26 ++
 rtl/tetris_key_controller.sv | 121 ++++++++++++
 tb/tb_tetris_key_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared keycodes, action and state encodings for the Tetris keyboard front end.
// decode_key maps a HID usage code onto the game action it triggers.
package tetris_pkg;

   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_Z     = 8'h1D;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_LEFT,
      ACT_RIGHT,
      ACT_DROP,
      ACT_CW,
      ACT_CCW,
      ACT_HARD
   } action_e;

   typedef enum logic [1:0] {
      StIdle,
      StDas,
      StRepeat,
      StLocked
   } state_e;

   function automatic action_e decode_key(input logic [7:0] key);
      action_e act;
      unique case (key)
         KEY_LEFT:  act = ACT_LEFT;
         KEY_RIGHT: act = ACT_RIGHT;
         KEY_DOWN:  act = ACT_DROP;
         KEY_UP:    act = ACT_CW;
         KEY_Z:     act = ACT_CCW;
         KEY_SPACE: act = ACT_HARD;
         default:   act = ACT_NONE;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Frame counter for DAS/ARR timing: expire is high on the tick that completes
// a period, and the counter restarts from zero on expire or clear.
module key_repeat_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       tick,
   input  logic [7:0] period,
   output logic       expire
);

   logic [7:0] cnt_q;

   assign expire = tick && (cnt_q == period - 8'd1);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= 8'd0;
      end else if (expire) begin
         cnt_q <= 8'd0;
      end else if (tick) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/tetris_key_controller.sv
// Turns the held HID keycode into one-cycle game-action pulses with
// press detection, delayed auto-shift, auto-repeat and soft-drop repeat.
module tetris_key_controller
   import tetris_pkg::*;
#(
   parameter int unsigned DAS_FRAMES       = 10,
   parameter int unsigned ARR_FRAMES       = 2,
   parameter int unsigned SOFT_DROP_FRAMES = 2
) (
   input  logic       clk_clk,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   input  logic       enable,
   output logic       move_left,
   output logic       move_right,
   output logic       soft_drop,
   output logic       rotate_cw,
   output logic       rotate_ccw,
   output logic       hard_drop
);

   localparam logic [7:0] DasPeriod  = 8'(DAS_FRAMES);
   localparam logic [7:0] ArrPeriod  = 8'(ARR_FRAMES);
   localparam logic [7:0] DropPeriod = 8'(SOFT_DROP_FRAMES);

   logic [7:0] key_q;
   logic       tick_q;
   logic [7:0] held_q, held_d;
   state_e     state_q, state_d;
   action_e    act_q, act_d;

   logic       new_press, release_key;
   logic       tmr_tick, tmr_clear, expire;
   logic [7:0] period;

   // The tick is registered alongside the keycode so press/tick collisions line up.
   always_ff @(posedge clk_clk) begin
      if (reset) begin
         key_q   <= 8'h00;
         tick_q  <= 1'b0;
         held_q  <= 8'h00;
         state_q <= StIdle;
         act_q   <= ACT_NONE;
      end else begin
         key_q   <= keycode;
         tick_q  <= frame_tick;
         held_q  <= held_d;
         state_q <= state_d;
         act_q   <= act_d;
      end
   end

   assign new_press   = (key_q != 8'h00) && (key_q != held_q);
   assign release_key = (key_q == 8'h00);

   always_comb begin
      if (state_q == StDas)         period = DasPeriod;
      else if (held_q == KEY_DOWN)  period = DropPeriod;
      else                          period = ArrPeriod;
   end

   assign tmr_clear = new_press || release_key;
   assign tmr_tick  = tick_q && enable && ((state_q == StDas) || (state_q == StRepeat));

   key_repeat_timer u_timer (
      .clk    (clk_clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .tick   (tmr_tick),
      .period (period),
      .expire (expire)
   );

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      act_d   = ACT_NONE;
      if (release_key) begin
         state_d = StIdle;
         held_d  = 8'h00;
      end else if (new_press) begin
         held_d = key_q;
         if (!enable) begin
            state_d = StLocked;
         end else begin
            act_d = decode_key(key_q);
            unique case (act_d)
               ACT_LEFT, ACT_RIGHT: state_d = StDas;
               ACT_DROP:            state_d = StRepeat;
               default:             state_d = StLocked;
            endcase
         end
      end else if (!enable) begin
         // A key held while disabled must be re-pressed before it fires again.
         if (state_q != StIdle) state_d = StLocked;
      end else if (expire) begin
         act_d = decode_key(held_q);
         if (state_q == StDas) state_d = StRepeat;
      end
   end

   always_comb begin
      move_left  = 1'b0;
      move_right = 1'b0;
      soft_drop  = 1'b0;
      rotate_cw  = 1'b0;
      rotate_ccw = 1'b0;
      hard_drop  = 1'b0;
      unique case (act_q)
         ACT_LEFT:  move_left  = 1'b1;
         ACT_RIGHT: move_right = 1'b1;
         ACT_DROP:  soft_drop  = 1'b1;
         ACT_CW:    rotate_cw  = 1'b1;
         ACT_CCW:   rotate_ccw = 1'b1;
         ACT_HARD:  hard_drop  = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: tb/tb_tetris_key_controller.sv
// Directed and random stimulus for tetris_key_controller, checked cycle by cycle
// against a tick-counting reference model of the key repeat rules.
module tb_tetris_key_controller;

   localparam int DAS = 10;
   localparam int ARR = 2;
   localparam int SD  = 2;

   logic       clk_clk = 1'b0;
   logic       reset;
   logic [7:0] keycode;
   logic       frame_tick;
   logic       enable;
   logic       move_left, move_right, soft_drop, rotate_cw, rotate_ccw, hard_drop;

   int checks = 0;
   int errors = 0;
   int pcnt[6];

   // Reference model state: value seen by the previous edge, key in service,
   // ticks since its press, and whether it may still fire.
   int kq = 0;
   int tq = 0;
   int held = 0;
   int ticks = 0;
   bit live = 0;
   int exp_act = 0;

   tetris_key_controller #(
      .DAS_FRAMES       (DAS),
      .ARR_FRAMES       (ARR),
      .SOFT_DROP_FRAMES (SD)
   ) dut (
      .clk_clk    (clk_clk),
      .reset      (reset),
      .keycode    (keycode),
      .frame_tick (frame_tick),
      .enable     (enable),
      .move_left  (move_left),
      .move_right (move_right),
      .soft_drop  (soft_drop),
      .rotate_cw  (rotate_cw),
      .rotate_ccw (rotate_ccw),
      .hard_drop  (hard_drop)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // 1 left, 2 right, 3 soft drop, 4 cw, 5 ccw, 6 hard drop, 0 unmapped
   function automatic int act_of(input int k);
      case (k)
         8'h50:   return 1;
         8'h4F:   return 2;
         8'h51:   return 3;
         8'h52:   return 4;
         8'h1D:   return 5;
         8'h2C:   return 6;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int a;
      exp_act = 0;
      if (reset) begin
         held = 0; ticks = 0; live = 0; kq = 0; tq = 0;
         return;
      end
      if (kq == 0) begin
         held = 0;
         live = 0;
      end else if (kq != held) begin
         held  = kq;
         ticks = 0;
         live  = enable;
         if (enable) exp_act = act_of(kq);
      end else if (!enable) begin
         live = 0;
      end else if (live && tq != 0) begin
         ticks++;
         a = act_of(held);
         if ((a == 1 || a == 2) && ticks >= DAS && (ticks - DAS) % ARR == 0) exp_act = a;
         else if (a == 3 && ticks % SD == 0) exp_act = a;
      end
      kq = keycode;
      tq = frame_tick;
   endtask

   function automatic logic [5:0] outs();
      return {hard_drop, rotate_ccw, rotate_cw, soft_drop, move_right, move_left};
   endfunction

   task automatic cycle();
      logic [5:0] got, want;
      @(posedge clk_clk);
      model_step();
      #1;
      got  = outs();
      want = (exp_act == 0) ? 6'b0 : 6'(1 << (exp_act - 1));
      check("pulses", 32'(got), 32'(want));
      if ($countones(got) > 1) check("onehot", 32'($countones(got)), 32'd1);
      for (int i = 0; i < 6; i++) if (got[i]) pcnt[i]++;
      @(negedge clk_clk);
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 6; i++) pcnt[i] = 0;
   endtask

   task automatic hold(input logic [7:0] k, input int nticks);
      int n;
      int c;
      n = 0;
      c = 0;
      keycode = k;
      while (n < nticks) begin
         frame_tick = (c % 3 == 2);
         if (frame_tick) n++;
         c++;
         cycle();
      end
      frame_tick = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic release_key(input int n);
      keycode = 8'h00;
      frame_tick = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      reset = 1'b1;
      keycode = 8'h00;
      frame_tick = 1'b0;
      enable = 1'b1;
      @(negedge clk_clk);
      repeat (3) cycle();
      check("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      repeat (2) cycle();

      // Left press and hold: press + ticks 10,12,...,20
      clr_counts();
      hold(8'h50, 20);
      check("left_hold_cnt", pcnt[0], 7);
      release_key(3);

      // Rotate hold fires once, re-press fires again
      clr_counts();
      hold(8'h52, 30);
      check("rot_hold_cnt", pcnt[3], 1);
      release_key(3);
      hold(8'h52, 2);
      check("rot_repress_cnt", pcnt[3], 2);
      release_key(3);

      // Key change restarts DAS
      clr_counts();
      hold(8'h50, 5);
      hold(8'h4F, 9);
      check("chg_right_pre", pcnt[1], 1);
      hold(8'h4F, 1);
      check("chg_right_das", pcnt[1], 2);
      check("chg_left_cnt", pcnt[0], 1);
      release_key(3);

      // Soft drop: press + ticks 2,4,6
      clr_counts();
      hold(8'h51, 6);
      check("drop_cnt", pcnt[2], 4);
      release_key(3);

      // Enable gating
      clr_counts();
      enable = 1'b0;
      hold(8'h4F, 3);
      enable = 1'b1;
      hold(8'h4F, 17);
      check("en_gate_cnt", pcnt[1], 0);
      release_key(3);
      hold(8'h4F, 2);
      check("en_repress_cnt", pcnt[1], 1);
      release_key(3);

      // Press coincident with a tick: that tick is not counted
      clr_counts();
      keycode = 8'h50;
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
      hold(8'h50, 9);
      check("coll_9_cnt", pcnt[0], 1);
      hold(8'h50, 1);
      check("coll_10_cnt", pcnt[0], 2);

      // Reset during REPEAT, key still held afterwards is a new press
      hold(8'h50, 4);
      reset = 1'b1;
      cycle();
      check("rst_mid_outs", 32'(outs()), 32'd0);
      check("rst_mid_state", 32'(dut.state_q), 32'(tetris_pkg::StIdle));
      reset = 1'b0;
      clr_counts();
      repeat (3) cycle();
      check("rst_repress_cnt", pcnt[0], 1);
      release_key(3);

      // Random phase
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 8))
               0, 1:    keycode = 8'h00;
               2:       keycode = 8'h50;
               3:       keycode = 8'h4F;
               4:       keycode = 8'h51;
               5:       keycode = 8'h52;
               6:       keycode = 8'h1D;
               7:       keycode = 8'h2C;
               default: keycode = 8'h07;
            endcase
         end
         frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         reset = ($urandom_range(0, 499) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
